// File: rtl/pwm_pkg.sv
// Shared definitions for the complementary PWM / dead-time generator.
//   STATE_W     : width of the dead-time FSM state encoding
//   pwm_state_e : FSM states; pwm_hi is driven only in HI_ON and
//                 pwm_lo only in LO_ON, every other state drives both low.
package pwm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    LO_ON    = 3'd1,
    DT_TO_HI = 3'd2,
    HI_ON    = 3'd3,
    DT_TO_LO = 3'd4
  } pwm_state_e;

endpackage

// File: rtl/deadtime_fsm.sv
// Dead-time insertion FSM. Turns the registered compare result raw_q into a
// complementary output pair, with a programmable gap where both are low.
//   clk, rst   : clock, synchronous active-high reset
//   en         : 0 sends the FSM to IDLE on the next cycle (both outputs low)
//   raw_q      : registered "count < duty" compare, 1 = high side requested
//   dead_time  : gap length in cycles, sampled when a dead-time state is entered
//   pwm_hi     : high-side drive, only in HI_ON
//   pwm_lo     : low-side drive, only in LO_ON
//   state      : current state register, for debug/observation
module deadtime_fsm
  import pwm_pkg::*;
#(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw_q,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm_hi,
  output logic            pwm_lo,
  output pwm_state_e      state
);

  localparam logic [DT_W-1:0] DT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0] DT_ZERO = '0;

  pwm_state_e      state_q, state_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic            dt_zero;

  assign dt_zero = (dead_time == DT_ZERO);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dt_cnt_q <= DT_ZERO;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
    end
  end

  // Next-state logic. Entering a dead-time state loads dead_time-1 so the
  // state lasts exactly dead_time cycles; dead_time==0 skips it entirely.
  // If raw_q reverts while waiting, the FSM falls back to the side it came
  // from without ever emitting the aborted pulse.
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LO_ON, HI_ON: begin
          // IDLE always passes through dead time, whichever side it starts on.
          if (raw_q && state_q != HI_ON) begin
            if (dt_zero) begin
              state_d = HI_ON;
            end else begin
              state_d  = DT_TO_HI;
              dt_cnt_d = dead_time - DT_ONE;
            end
          end else if (!raw_q && state_q != LO_ON) begin
            if (dt_zero) begin
              state_d = LO_ON;
            end else begin
              state_d  = DT_TO_LO;
              dt_cnt_d = dead_time - DT_ONE;
            end
          end
        end
        DT_TO_HI: begin
          if (!raw_q) begin
            state_d = LO_ON;
          end else if (dt_cnt_q == DT_ZERO) begin
            state_d = HI_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_ONE;
          end
        end
        DT_TO_LO: begin
          if (raw_q) begin
            state_d = HI_ON;
          end else if (dt_cnt_q == DT_ZERO) begin
            state_d = LO_ON;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register only, so they cannot overlap.
  always_comb begin
    pwm_hi = (state_q == HI_ON);
    pwm_lo = (state_q == LO_ON);
    state  = state_q;
  end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM generator with dead time, fed by an upstream
// free-running counter. Duty writes are double-buffered and take effect
// only at period boundaries.
//   clk, rst    : clock, synchronous active-high reset
//   en          : output enable, 0 forces both outputs low
//   count       : upstream counter value (N bits)
//   max_tick    : high on the last cycle of the counter period
//   duty        : requested high cycles per period (before dead time)
//   duty_valid  : duty write request
//   duty_ready  : buffer free; a write transfers when duty_valid && duty_ready
//   dead_time   : gap length in cycles (DT_W bits)
//   pwm_hi      : high-side drive
//   pwm_lo      : low-side drive
//   cycle_done  : one-cycle pulse the cycle after an enabled max_tick
//   dbg_state   : dead-time FSM state, for observation
//
// Handshake: a duty transfer happens on any rising edge where duty_valid and
// duty_ready are both high. duty_ready depends only on the buffer state, never
// on duty_valid; the producer must hold duty stable while waiting.
module pwm_deadtime_gen
  import pwm_pkg::*;
#(
  parameter int N    = 8,
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    count,
  input  logic            max_tick,
  input  logic [N-1:0]    duty,
  input  logic            duty_valid,
  output logic            duty_ready,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm_hi,
  output logic            pwm_lo,
  output logic            cycle_done,
  output pwm_state_e      dbg_state
);

  logic [N-1:0] active_duty;
  logic [N-1:0] pending;
  logic         pending_valid;
  logic         raw_q;
  logic         duty_fire;

  assign duty_ready = !pending_valid;
  assign duty_fire  = duty_valid && duty_ready;

  // The write and the boundary update are mutually exclusive: a write can
  // only land while the buffer is empty, so a write on a max_tick cycle is
  // held and applied at the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_duty   <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      raw_q         <= 1'b0;
      cycle_done    <= 1'b0;
    end else begin
      if (duty_fire) begin
        pending       <= duty;
        pending_valid <= 1'b1;
      end else if (max_tick && en && pending_valid) begin
        active_duty   <= pending;
        pending_valid <= 1'b0;
      end
      // Unsigned compare: duty 0 never high, duty above max count always high.
      raw_q      <= en && (count < active_duty);
      cycle_done <= en && max_tick;
    end
  end

  deadtime_fsm #(
    .DT_W (DT_W)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .raw_q     (raw_q),
    .dead_time (dead_time),
    .pwm_hi    (pwm_hi),
    .pwm_lo    (pwm_lo),
    .state     (dbg_state)
  );

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
module tb_pwm_deadtime_gen;
  import pwm_pkg::*;

  localparam int N       = 8;
  localparam int DT_W    = 4;
  localparam int MAX_VAL = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [N-1:0]    count = '0;
  logic            max_tick = 1'b0;
  logic [N-1:0]    duty = '0;
  logic            duty_valid = 1'b0;
  logic            duty_ready;
  logic [DT_W-1:0] dead_time = '0;
  logic            pwm_hi;
  logic            pwm_lo;
  logic            cycle_done;
  logic [STATE_W-1:0] dbg_state;

  pwm_deadtime_gen #(.N(N), .DT_W(DT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count      (count),
    .max_tick   (max_tick),
    .duty       (duty),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .dead_time  (dead_time),
    .pwm_hi     (pwm_hi),
    .pwm_lo     (pwm_lo),
    .cycle_done (cycle_done),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Output rule: the pair is "committed" to one side. When raw disagrees with
  // the committed side the outputs are both low; a side becomes committed
  // once raw has shown it for dead_time+1 consecutive cycles. Leaving idle,
  // the committed side is the opposite of the first raw value seen.
  logic [N-1:0] m_active, m_pend;
  logic         m_pend_v, m_r, m_idle, m_side, m_run_val;
  logic         m_hi, m_lo, m_cd;
  int           m_run_len;
  logic [3:0]   exp_q[$];

  always @(posedge clk) begin
    logic r_now;
    if (rst) begin
      m_active = '0; m_pend = '0; m_pend_v = 1'b0; m_r = 1'b0;
      m_idle = 1'b1; m_side = 1'b0; m_run_val = 1'b0; m_run_len = 0;
      m_hi = 1'b0; m_lo = 1'b0; m_cd = 1'b0;
    end else begin
      r_now = m_r;
      if (m_idle || r_now != m_run_val) begin
        m_run_val = r_now;
        m_run_len = 1;
      end else if (m_run_len < 1000) begin
        m_run_len++;
      end
      if (!en) begin
        m_idle = 1'b1;
      end else begin
        if (m_idle) begin
          m_idle = 1'b0;
          m_side = !r_now;
        end
        if (m_run_val != m_side && m_run_len >= int'(dead_time) + 1)
          m_side = m_run_val;
      end
      m_hi = !m_idle && (r_now == m_side) && m_side;
      m_lo = !m_idle && (r_now == m_side) && !m_side;
      m_cd = en && max_tick;
      m_r  = en && (count < m_active);
      if (duty_valid && !m_pend_v) begin
        m_pend = duty; m_pend_v = 1'b1;
      end else if (max_tick && en && m_pend_v) begin
        m_active = m_pend; m_pend_v = 1'b0;
      end
    end
    exp_q.push_back({m_hi, m_lo, m_cd, !m_pend_v});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [3:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_int("pwm_hi", int'(pwm_hi), int'(e[3]));
      cmp_int("pwm_lo", int'(pwm_lo), int'(e[2]));
      cmp_int("cycle_done", int'(cycle_done), int'(e[1]));
      cmp_int("duty_ready", int'(duty_ready), int'(e[0]));
      cmp_int("no_overlap", int'(pwm_hi && pwm_lo), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    count    = (count == N'(MAX_VAL)) ? '0 : count + 1'b1;
    max_tick = (count == N'(MAX_VAL));
  endtask

  task automatic wait_count(input int v);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (int'(count) == v) break;
    end
  endtask

  task automatic write_duty(input logic [N-1:0] d, output int acc_cnt);
    bit done;
    done = 1'b0;
    acc_cnt = -1;
    duty = d;
    duty_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (duty_ready) begin
        done = 1'b1;
        acc_cnt = int'(count);
      end
      tick();
    end
    duty_valid = 1'b0;
    cmp_int("write_accept", int'(done), 1);
  endtask

  task automatic measure(output int hi_n, output int lo_n);
    hi_n = 0;
    lo_n = 0;
    for (int i = 0; i <= MAX_VAL; i++) begin
      tick();
      hi_n += int'(pwm_hi);
      lo_n += int'(pwm_lo);
    end
  endtask

  task automatic wait_hi();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (pwm_hi) ok = 1'b1;
    end
    cmp_int("wait_hi", int'(ok), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi_n, lo_n, acc, n_low;
    bit seen, first_hi, vacc;

    repeat (3) tick();
    rst = 1'b0;
    cmp_int("reset_ready", int'(duty_ready), 1);
    cmp_int("reset_hi", int'(pwm_hi), 0);

    // duty 4, dead time 1: hi 3, lo 5, two 1-cycle gaps
    dead_time = 4'd1;
    write_duty(8'd4, acc);
    en = 1'b1;
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t1_hi_width", hi_n, 3);
    cmp_int("t1_lo_width", lo_n, 5);

    // dead time 0: hi 4, lo 6, no gap; then 0% and >100% duty
    en = 1'b0;
    repeat (2) tick();
    dead_time = 4'd0;
    en = 1'b1;
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t2_hi_width", hi_n, 4);
    cmp_int("t2_no_gap", hi_n + lo_n, 10);
    write_duty(8'd0, acc);
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t2_duty0_lo", lo_n, 10);
    write_duty(8'd12, acc);
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t2_duty12_hi", hi_n, 10);

    // buffered write stalls the next one until the boundary
    write_duty(8'd4, acc);
    repeat (25) tick();
    wait_count(3);
    write_duty(8'd7, acc);
    cmp_int("t3_ready_low", int'(duty_ready), 0);
    write_duty(8'd2, acc);
    cmp_int("t3_accept_at_wrap", acc, 0);
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t3_duty2_hi", hi_n, 2);
    cmp_int("t3_duty2_lo", lo_n, 8);

    // dead time 3: duty 5 gives hi 2 lo 2; duty 2 pulse is swallowed
    en = 1'b0;
    repeat (2) tick();
    dead_time = 4'd3;
    write_duty(8'd5, acc);
    en = 1'b1;
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t4_hi_width", hi_n, 2);
    cmp_int("t4_lo_width", lo_n, 2);
    write_duty(8'd2, acc);
    repeat (30) tick();
    measure(hi_n, lo_n);
    cmp_int("t4_short_hi", hi_n, 0);
    cmp_int("t4_short_lo", lo_n, 8);

    // en drop during HI_ON, then restart goes through dead time
    write_duty(8'd5, acc);
    repeat (30) tick();
    wait_hi();
    en = 1'b0;
    tick();
    cmp_int("t5_off_hi", int'(pwm_hi), 0);
    cmp_int("t5_off_lo", int'(pwm_lo), 0);
    repeat (3) tick();
    wait_count(6);
    en = 1'b1;
    n_low = 0;
    seen = 1'b0;
    first_hi = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (pwm_hi || pwm_lo) begin
        seen = 1'b1;
        first_hi = pwm_hi;
      end else begin
        n_low++;
      end
    end
    cmp_int("t5_restart_gap", n_low, 3);
    cmp_int("t5_restart_side_hi", int'(first_hi), 0);

    // reset during HI_ON with a pending write
    wait_hi();
    write_duty(8'd9, acc);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_int("t6_rst_hi", int'(pwm_hi), 0);
    cmp_int("t6_rst_lo", int'(pwm_lo), 0);
    cmp_int("t6_rst_ready", int'(duty_ready), 1);
    repeat (20) tick();
    measure(hi_n, lo_n);
    cmp_int("t6_duty_cleared_hi", hi_n, 0);
    cmp_int("t6_duty_cleared_lo", lo_n, 10);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      vacc = duty_valid && duty_ready;
      tick();
      if (vacc) duty_valid = 1'b0;
      if (!duty_valid && $urandom_range(0, 7) == 0) begin
        duty = N'($urandom_range(0, 15));
        duty_valid = 1'b1;
      end
      rst = ($urandom_range(0, 149) == 0);
      if (en && $urandom_range(0, 59) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
      if (!en) begin
        if ($urandom_range(0, 9) == 0) dead_time = 4'd15;
        else dead_time = DT_W'($urandom_range(0, 5));
      end
    end
    rst = 1'b0;
    duty_valid = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
